// File: rtl/fb_read_arbiter_if.sv
// Frame-buffer read-port bundle: display requester, engine requester and the
// single read port of the frame buffer. The arbiter sits on the slave side.
interface fb_read_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              disp_req;
  logic [16:0]       disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              disp_err;

  logic              eng_valid;
  logic [16:0]       eng_addr;
  logic              eng_ready;
  logic [DATA_W-1:0] eng_rdata;
  logic              eng_rvalid;
  logic              eng_err;
  logic              eng_clr_stats;
  logic [15:0]       wait_cnt;

  logic              mem_en;
  logic [16:0]       mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, eng_valid, eng_addr, eng_clr_stats, mem_rdata,
    output disp_rdata, disp_rvalid, disp_err,
    output eng_ready, eng_rdata, eng_rvalid, eng_err, wait_cnt,
    output mem_en, mem_addr
  );

  modport master (
    output disp_req, disp_addr, eng_valid, eng_addr, eng_clr_stats, mem_rdata,
    input  disp_rdata, disp_rvalid, disp_err,
    input  eng_ready, eng_rdata, eng_rvalid, eng_err, wait_cnt,
    input  mem_en, mem_addr
  );
endinterface

// File: rtl/fb_read_arbiter.sv
// Single-port frame-buffer read arbiter: display has absolute priority, the
// engine fills every free cycle, responses are routed back by a tag pipeline.
module fb_read_arbiter #(
  parameter int DATA_W   = 16,
  parameter int FB_WORDS = 76800,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  fb_read_arbiter_if.slave  bus
);

  typedef struct packed {
    logic valid;
    logic owner;  // 0 = display, 1 = engine
    logic oor;
  } tag_t;

  localparam logic        OWNER_DISP = 1'b0;
  localparam logic        OWNER_ENG  = 1'b1;
  localparam logic [16:0] ADDR_LIMIT = 17'(FB_WORDS);

  logic        mem_en_q,   mem_en_d;
  logic [16:0] mem_addr_q, mem_addr_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  tag_t        tag_q [RD_LAT+1];
  tag_t        tag_d [RD_LAT+1];

  logic        issue_valid;
  logic        issue_oor;
  logic [16:0] issue_addr;
  tag_t        ret;
  logic [DATA_W-1:0] ret_data;

  always_comb begin
    issue_valid = bus.disp_req | bus.eng_valid;
    issue_addr  = bus.disp_req ? bus.disp_addr : bus.eng_addr;
    issue_oor   = issue_addr >= ADDR_LIMIT;

    // Out-of-range requests still occupy a slot so they return err at normal latency.
    mem_en_d   = issue_valid && !issue_oor;
    mem_addr_d = issue_valid ? issue_addr : mem_addr_q;

    tag_d[0] = '{valid: issue_valid,
                 owner: bus.disp_req ? OWNER_DISP : OWNER_ENG,
                 oor:   issue_valid && issue_oor};
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end

    wait_cnt_d = wait_cnt_q;
    if (bus.eng_clr_stats) begin
      wait_cnt_d = '0;
    end else if (bus.eng_valid && bus.disp_req && wait_cnt_q != 16'hFFFF) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the tag pipeline
  // is reset so in-flight reads are dropped, while read data needs no reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      wait_cnt_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      wait_cnt_q <= wait_cnt_d;
      tag_q      <= tag_d;
    end
  end

  assign ret      = tag_q[RD_LAT];
  assign ret_data = ret.oor ? '0 : bus.mem_rdata;

  assign bus.eng_ready   = bus.eng_valid && !bus.disp_req;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.wait_cnt    = wait_cnt_q;

  assign bus.disp_rvalid = ret.valid && (ret.owner == OWNER_DISP);
  assign bus.disp_err    = bus.disp_rvalid && ret.oor;
  assign bus.disp_rdata  = ret_data;
  assign bus.eng_rvalid  = ret.valid && (ret.owner == OWNER_ENG);
  assign bus.eng_err     = bus.eng_rvalid && ret.oor;
  assign bus.eng_rdata   = ret_data;

endmodule

// File: doc/fb_read_arbiter.md
# fb_read_arbiter

Shares the single read port of the 320x240 frame buffer between two requesters: the display path (VGA-side address generator, fixed pixel timing) and the stereo matching engine (SAD/Census window fetch, valid/ready handshake). Display requests have absolute priority. The engine takes every free cycle. Read data is routed back to the issuing requester after the memory latency. Out-of-range addresses are trapped, and engine starvation is counted.

## Interface
- DATA_W, 16, frame-buffer word width
- FB_WORDS, 76800, number of valid words (320*240); legal addresses are 0..FB_WORDS-1
- RD_LAT, 1, frame-buffer read latency in cycles (1..4)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- disp_req  in  1  display read request, one word per cycle
- disp_addr  in  17  display read address
- disp_rdata  out  DATA_W  display read data
- disp_rvalid  out  1  disp_rdata valid, one-cycle pulse per request
- disp_err  out  1  pulses with disp_rvalid when the request was out of range
- eng_valid  in  1  engine request valid
- eng_addr  in  17  engine read address, held stable while eng_valid && !eng_ready
- eng_ready  out  1  engine request accepted this cycle
- eng_rdata  out  DATA_W  engine read data
- eng_rvalid  out  1  eng_rdata valid, one-cycle pulse per accepted request
- eng_err  out  1  pulses with eng_rvalid when the request was out of range
- eng_clr_stats  in  1  synchronous clear of wait_cnt
- wait_cnt  out  16  saturating count of engine stall cycles
- mem_en  out  1  frame-buffer read enable (registered)
- mem_addr  out  17  frame-buffer read address (registered)
- mem_rdata  in  DATA_W  frame-buffer read data

## Operation
- Arbitration (combinational, per cycle):
  - grant_disp = disp_req
  - eng_ready = eng_valid && !disp_req
  - No fairness override. Display timing is never stalled.
- Issue stage (registered at each edge):
  - If disp_req: mem_addr<=disp_addr. mem_en<=1 if disp_addr<FB_WORDS, else 0.
  - Else if eng_valid: same rule using eng_addr.
  - Else mem_en<=0 and mem_addr holds its previous value.
- Tag pipeline: RD_LAT+1 stages, each {valid, owner (0=disp, 1=eng), oor}. Stage 0 is loaded with the issue stage. The pipeline shifts every cycle and never stalls.
- Return stage, from the last stage:
  - The owner's rvalid = stage valid.
  - The owner's rdata = oor ? 0 : mem_rdata.
  - The owner's err = valid && oor.
  - The non-owner's rvalid and err are 0.
  - rdata outputs are don't-care when the matching rvalid=0. The bench checks them only under rvalid.
- Out-of-range request (addr>=FB_WORDS, including 76800..131071):
  - No memory access.
  - The handshake still completes: display is implicitly accepted; engine sees eng_ready=1.
  - Data 0 returns at normal latency with err=1.
- wait_cnt:
  - Increments on each cycle with eng_valid && disp_req, saturating at 16'hFFFF.
  - eng_clr_stats sets it to 0. Clear has priority over an increment in the same cycle.
- Reset, asynchronous and effective mid-operation:
  - mem_en=0, mem_addr=0, all tag stages invalid, wait_cnt=0.
  - All rvalid/err outputs are 0. In-flight reads are dropped; no rvalid is produced for requests issued before reset.

## Timing
- Define cycle n as the interval after edge n.
- A request sampled at edge n drives mem_en/mem_addr in cycle n, and its rvalid/err are high in cycle n+RD_LAT.
- With RD_LAT=1, data returns one cycle after issue.
- Throughput is one read per cycle total. The display is 100% served. The engine is served in every cycle with disp_req=0.
- Back-to-back requests from alternating owners return in issue order with no bubbles.
- eng_ready depends combinationally on eng_valid and disp_req. There is no path from any output back to eng_ready.
- Reset output values: mem_en=0, mem_addr=0, disp_rvalid=0, eng_rvalid=0, disp_err=0, eng_err=0, wait_cnt=0. eng_ready follows its combinational equation (0 while eng_valid=0).

## Test plan
- Engine only, RD_LAT=1, eng_addr=0,1,2 on consecutive cycles, memory model returns addr+16'h100 -> eng_ready=1 each cycle; eng_rvalid in cycles n+1..n+3 with data 0x100,0x101,0x102; disp_rvalid stays 0.
- Both requesting for 5 cycles (disp_addr=10..14, eng_addr=500) then disp_req=0 -> eng_ready=0 for 5 cycles, then 1; wait_cnt=5; the display reads 10..14 return first, then the engine read of 500.
- disp_addr=76800 and then eng_addr=131071 -> mem_en=0 in both issue cycles; disp_rvalid=1 with disp_err=1 and data 0; eng_rvalid=1 with eng_err=1 and data 0. Address 76799 is issued normally with err=0.
- Run with RD_LAT=3 and alternating disp/eng requests every cycle -> each response appears exactly 3 cycles after its issue, in issue order, routed to the correct owner.
- Assert reset while 2 reads are in flight -> all outputs go to reset values immediately; no rvalid after reset deasserts. A new request after reset returns normally.
- Force eng_valid=1 and disp_req=1 for 70000 cycles -> wait_cnt saturates at 0xFFFF. Assert eng_clr_stats in a stalled cycle -> wait_cnt=0 the next cycle, not 1.
